keypad_emulator: RTL and testbench

- Responder end of the 4x4 matrix-keypad scan interface. It drives the ROWS lines that the keypad scanner samples, in response to that scanner's COLS strobes.
- A host (bench, UART command path or self-test sequencer) submits hex key codes through a valid/ready handshake. For each code the block "presses" the matching key for a programmed hold time, then releases it for a gap time.
- Purpose: hardware self-test and closed-loop simulation of the keypad-to-hex-display path without a physical keypad.

---
 rtl/keypad_pkg.sv | 28 ++
 rtl/keypad_emu_matrix.sv | 26 ++
 rtl/keypad_emulator.sv | 136 +++++++++++++
 tb/tb_keypad_emulator.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and key map for the matrix-keypad emulator.
// The map is row-major: 1 2 3 A / 4 5 6 B / 7 8 9 C / E(*) 0 F(#) D.
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS,
    RELEASE
  } state_e;

  localparam logic [3:0] ROWS_IDLE = 4'hF;

  // Indexed by hex code 0..F.
  localparam logic [1:0] KEY_ROW [16] = '{
    2'd3, 2'd0, 2'd0, 2'd0,   // 0 1 2 3
    2'd1, 2'd1, 2'd1, 2'd2,   // 4 5 6 7
    2'd2, 2'd2, 2'd0, 2'd1,   // 8 9 A B
    2'd2, 2'd3, 2'd3, 2'd3    // C D E F
  };

  localparam logic [1:0] KEY_COL [16] = '{
    2'd1, 2'd0, 2'd1, 2'd2,   // 0 1 2 3
    2'd0, 2'd1, 2'd2, 2'd0,   // 4 5 6 7
    2'd1, 2'd2, 2'd3, 2'd3,   // 8 9 A B
    2'd3, 2'd3, 2'd0, 2'd2    // C D E F
  };

endpackage

// File: rtl/keypad_emu_matrix.sv
// Passive switch model: a closed contact ties the key's row low whenever
// the scanner pulls that key's column low. Purely combinational.
module keypad_emu_matrix
  import keypad_pkg::*;
(
  input  logic [3:0] cols,
  input  logic       contact,
  input  logic [3:0] code,
  output logic [3:0] rows
);

  logic [3:0] hit;
  logic       col_low;

  assign col_low = ~cols[KEY_COL[code]];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_row
      assign hit[gi] = contact && (KEY_ROW[code] == 2'(gi)) && col_low;
    end
  endgenerate

  assign rows = ROWS_IDLE & ~hit;

endmodule

// File: rtl/keypad_emulator.sv
// Keypad responder: presses each submitted hex key for HOLD_CYCLES, then
// releases it for RELEASE_CYCLES. Optional contact bounce: KEYPAD_EMU_BOUNCE_EN.
module keypad_emulator
  import keypad_pkg::*;
#(
  parameter int HOLD_CYCLES    = 2000000,
  parameter int RELEASE_CYCLES = 2000000,
  parameter int BOUNCE_CYCLES  = 50000,
  parameter int BOUNCE_PERIOD  = 5000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [3:0] KEY_CODE,
  input  logic       KEY_VALID,
  output logic       KEY_READY,
  input  logic [3:0] COLS,
  output logic [3:0] ROWS,
  output logic       BUSY,
  output logic       DONE
);

  localparam int MAX_CYCLES = (HOLD_CYCLES > RELEASE_CYCLES) ? HOLD_CYCLES : RELEASE_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  generate
    if (HOLD_CYCLES < 1) begin : g_bad_hold
      $error("keypad_emulator: HOLD_CYCLES must be at least 1");
    end
    if (RELEASE_CYCLES < 1) begin : g_bad_release
      $error("keypad_emulator: RELEASE_CYCLES must be at least 1");
    end
    if (BOUNCE_PERIOD < 1 || BOUNCE_CYCLES < 0) begin : g_bad_bounce
      $error("keypad_emulator: BOUNCE_PERIOD must be positive, BOUNCE_CYCLES non-negative");
    end
  endgenerate

  state_e        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [3:0]    code_reg, code_next;
  logic          done;
  logic          contact;

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      code_reg  <= 4'h0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      code_reg  <= code_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    code_next  = code_reg;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (KEY_VALID) begin
          code_next  = KEY_CODE;
          cnt_next   = '0;
          state_next = PRESS;
        end
      end
      PRESS: begin
        if (cnt_reg == CW'(HOLD_CYCLES - 1)) begin
          cnt_next   = '0;
          state_next = RELEASE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      RELEASE: begin
        if (cnt_reg == CW'(RELEASE_CYCLES - 1)) begin
          cnt_next   = '0;
          state_next = IDLE;
          done       = 1'b1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef KEYPAD_EMU_BOUNCE_EN
  localparam int MIN_CYCLES = (HOLD_CYCLES < RELEASE_CYCLES) ? HOLD_CYCLES : RELEASE_CYCLES;
  localparam int BW         = (BOUNCE_PERIOD > 1) ? $clog2(BOUNCE_PERIOD) : 1;

  generate
    if (BOUNCE_CYCLES >= MIN_CYCLES) begin : g_bad_window
      $error("keypad_emulator: BOUNCE_CYCLES must be below both phase lengths");
    end
  endgenerate

  logic [BW-1:0] bp_cnt_reg;
  logic          flip_reg;
  logic          in_window;

  // Phase restarts on every state change so each window begins at nominal.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      bp_cnt_reg <= '0;
      flip_reg   <= 1'b0;
    end else if (state_next != state_reg) begin
      bp_cnt_reg <= '0;
      flip_reg   <= 1'b0;
    end else if (bp_cnt_reg == BW'(BOUNCE_PERIOD - 1)) begin
      bp_cnt_reg <= '0;
      flip_reg   <= ~flip_reg;
    end else begin
      bp_cnt_reg <= bp_cnt_reg + 1'b1;
    end
  end

  assign in_window = (state_reg != IDLE) && (cnt_reg < CW'(BOUNCE_CYCLES));
  assign contact   = (state_reg == PRESS) ^ (in_window & flip_reg);
`else
  assign contact = (state_reg == PRESS);
`endif

  keypad_emu_matrix u_matrix (
    .cols    (COLS),
    .contact (contact),
    .code    (code_reg),
    .rows    (ROWS)
  );

  assign KEY_READY = (state_reg == IDLE);
  assign BUSY      = ~KEY_READY;
  assign DONE      = done;

endmodule

// File: tb/tb_keypad_emulator.sv
// Directed bench for keypad_emulator (HOLD=20, RELEASE=10, BOUNCE=6, PERIOD=2).
// Bounce-pattern steps run only when KEYPAD_EMU_BOUNCE_EN is defined.
module tb_keypad_emulator;

  localparam int HOLD   = 20;
  localparam int REL    = 10;
  localparam int BOUNCE = 6;
  localparam int BPER   = 2;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready;
  logic [3:0] cols;
  logic [3:0] rows;
  logic       busy;
  logic       done;

  int n_cmp = 0;
  int n_bad = 0;

  keypad_emulator #(
    .HOLD_CYCLES    (HOLD),
    .RELEASE_CYCLES (REL),
    .BOUNCE_CYCLES  (BOUNCE),
    .BOUNCE_PERIOD  (BPER)
  ) dut (
    .CLK       (clk),
    .RESET     (reset_n),
    .KEY_CODE  (key_code),
    .KEY_VALID (key_valid),
    .KEY_READY (key_ready),
    .COLS      (cols),
    .ROWS      (rows),
    .BUSY      (busy),
    .DONE      (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("check %-16s observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic probe(input string tag, input logic [3:0] c, input logic [3:0] exp);
    cols = c;
    #1;
    chk(tag, {28'd0, rows}, {28'd0, exp});
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while (done !== 1'b1 && k < 200) begin
      tick();
      k++;
    end
    chk(tag, {31'd0, done}, 32'd1);
  endtask

  initial begin
    int n;
    int dones;
    logic closed;

    reset_n   = 1'b0;
    key_code  = 4'h0;
    key_valid = 1'b0;
    cols      = 4'hF;

    // Reset held for three cycles.
    tick(); tick(); tick();
    reset_n = 1'b1;
    chk("rst_ready", {31'd0, key_ready}, 32'd1);
    chk("rst_busy",  {31'd0, busy},      32'd0);
    chk("rst_done",  {31'd0, done},      32'd0);
    chk("rst_rows",  {28'd0, rows},      32'hF);
    probe("idle_colE", 4'hE, 4'hF);
    probe("idle_colD", 4'hD, 4'hF);
    probe("idle_colB", 4'hB, 4'hF);
    probe("idle_col7", 4'h7, 4'hF);

    // Key 6 (row 1, col 2), VALID for one cycle.
    key_code  = 4'h6;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    chk("k6_ready", {31'd0, key_ready}, 32'd0);
    chk("k6_busy",  {31'd0, busy},      32'd1);
    probe("k6_colE", 4'hE, 4'hF);
    probe("k6_colD", 4'hD, 4'hF);
    probe("k6_colB", 4'hB, 4'hD);
    probe("k6_col7", 4'h7, 4'hF);
    probe("k6_colF", 4'hF, 4'hF);
    cols = 4'hB;
    // n counts clock edges starting from the accepting edge.
    n = 1;
    while (done !== 1'b1 && n < 200) begin
      tick();
      n++;
      if (n == 25) chk("k6_rel_rows", {28'd0, rows}, 32'hF);
    end
    chk("k6_done_lat", n, 32'd30);
    tick();
    chk("k6_done_pulse", {31'd0, done},      32'd0);
    chk("k6_ready_back", {31'd0, key_ready}, 32'd1);

    // Key E, then key D presented with VALID held through the E sequence.
    key_code  = 4'hE;
    key_valid = 1'b1;
    tick();
    probe("kE_colE", 4'hE, 4'h7);
    probe("kE_col7", 4'h7, 4'hF);
    key_code = 4'hD;
    wait_done("kE_done");
    chk("kE_ready_at_done", {31'd0, key_ready}, 32'd0);
    tick();
    chk("kD_ready_after", {31'd0, key_ready}, 32'd1);
    tick();
    key_valid = 1'b0;
    chk("kD_taken", {31'd0, busy}, 32'd1);
    probe("kD_col7", 4'h7, 4'h7);
    probe("kD_colE", 4'hE, 4'hF);
    wait_done("kD_done");
    tick();

    // Key 9 running; VALID with key 1 mid-PRESS must be ignored.
    key_code  = 4'h9;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    tick(); tick(); tick(); tick();
    key_code  = 4'h1;
    key_valid = 1'b1;
    chk("k1_not_ready", {31'd0, key_ready}, 32'd0);
    probe("k9_colB", 4'hB, 4'hB);
    probe("k1_ignored", 4'hE, 4'hF);
    wait_done("k9_done");
    tick();
    chk("k1_ready", {31'd0, key_ready}, 32'd1);
    tick();
    key_valid = 1'b0;
    chk("k1_busy", {31'd0, busy}, 32'd1);
    probe("k1_colE", 4'hE, 4'hE);
    probe("k1_colD", 4'hD, 4'hF);
    wait_done("k1_done");
    tick();

    // Key 5 (row 1, col 1), reset asserted in PRESS cycle 10.
    key_code  = 4'h5;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    probe("k5_pressed", 4'hD, 4'hD);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("k5_rst_rows",  {28'd0, rows},      32'hF);
    chk("k5_rst_ready", {31'd0, key_ready}, 32'd1);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) dones++;
      tick();
    end
    chk("k5_no_done", dones, 32'd0);

`ifdef KEYPAD_EMU_BOUNCE_EN
    // Key 0 (row 3, col 1) with column 1 held low for the whole sequence.
    cols      = 4'hD;
    key_code  = 4'h0;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    for (int i = 0; i < HOLD; i++) begin
      closed = (i < BOUNCE) ? (((i / BPER) % 2) == 0) : 1'b1;
      chk($sformatf("bnc_press%0d", i), {28'd0, rows}, closed ? 32'h7 : 32'hF);
      tick();
    end
    for (int i = 0; i < REL; i++) begin
      closed = (i < BOUNCE) ? (((i / BPER) % 2) == 1) : 1'b0;
      chk($sformatf("bnc_rel%0d", i), {28'd0, rows}, closed ? 32'h7 : 32'hF);
      tick();
    end
    chk("bnc_idle", {31'd0, key_ready}, 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
